// File: rtl/regression_error_stats.sv
// regression_error_stats
// ----------------------
// Reduces one dataset of N signed residuals into fit-quality statistics:
// sum of squared errors, sum of absolute errors, the largest absolute error
// together with the index where it first occurs, and a count of outliers
// above a programmable threshold.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high; returns to IDLE and clears everything
//   start      begin a new collection (taken in IDLE or DONE only)
//   ei_valid   residual strobe
//   ei         signed two's-complement residual (W bits)
//   threshold  unsigned outlier threshold, held stable while collecting
//   busy       high while collecting
//   done       high once all N samples are in, held until the next start
//   sse        sum of ei^2 (SW bits, unsigned)
//   sae        sum of |ei| (W+CW bits, unsigned)
//   max_abs    largest |ei| seen so far
//   max_idx    0-based index of the first sample that reached max_abs
//   outliers   number of samples with |ei| > threshold
module regression_error_stats #(
  parameter int W  = 20,
  parameter int N  = 150,
  parameter int CW = 8,
  parameter int SW = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ei_valid,
  input  logic [W-1:0]      ei,
  input  logic [W-1:0]      threshold,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     sse,
  output logic [W+CW-1:0]   sae,
  output logic [W-1:0]      max_abs,
  output logic [CW-1:0]     max_idx,
  output logic [CW-1:0]     outliers
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [SW-1:0]     sse_q;
  logic [W+CW-1:0]   sae_q;
  logic [W-1:0]      max_abs_q;
  logic [CW-1:0]     max_idx_q;
  logic [CW-1:0]     outliers_q;
  logic [CW-1:0]     cnt_q;

  logic [W-1:0]      abs_d;
  logic [2*W-1:0]    sq_d;
  logic [SW-1:0]     sse_d;
  logic [W+CW-1:0]   sae_d;
  logic              max_upd_d;
  logic              out_upd_d;

  // Per-sample arithmetic: magnitude, square and the candidate accumulator values.
  always_comb begin
    abs_d     = ei;
    sq_d      = {(2*W){1'b0}};
    sse_d     = sse_q;
    sae_d     = sae_q;
    max_upd_d = 1'b0;
    out_upd_d = 1'b0;
    // Two's-complement negate; the most negative code maps onto 2^(W-1),
    // which is still representable as a W-bit unsigned magnitude.
    if (ei[W-1]) begin
      abs_d = ~ei + W'(1);
    end else begin
      abs_d = ei;
    end
    sq_d      = {{W{1'b0}}, abs_d} * {{W{1'b0}}, abs_d};
    sse_d     = sse_q + SW'(sq_d);
    sae_d     = sae_q + (W+CW)'(abs_d);
    // Strict comparisons: ties keep the earlier index, equal-to-threshold is not an outlier.
    max_upd_d = (abs_d > max_abs_q);
    out_upd_d = (abs_d > threshold);
  end

  // Collection FSM with registered status flags and statistic accumulators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sse_q      <= {SW{1'b0}};
      sae_q      <= {(W+CW){1'b0}};
      max_abs_q  <= {W{1'b0}};
      max_idx_q  <= {CW{1'b0}};
      outliers_q <= {CW{1'b0}};
      cnt_q      <= {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // A strobe arriving with start is deliberately dropped here.
          if (start) begin
            state_q    <= COLLECT;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            sse_q      <= {SW{1'b0}};
            sae_q      <= {(W+CW){1'b0}};
            max_abs_q  <= {W{1'b0}};
            max_idx_q  <= {CW{1'b0}};
            outliers_q <= {CW{1'b0}};
            cnt_q      <= {CW{1'b0}};
          end else begin
            state_q <= state_q;
          end
        end
        COLLECT: begin
          if (ei_valid) begin
            sse_q <= sse_d;
            sae_q <= sae_d;
            if (max_upd_d) begin
              max_abs_q <= abs_d;
              max_idx_q <= cnt_q;
            end else begin
              max_abs_q <= max_abs_q;
            end
            if (out_upd_d) begin
              outliers_q <= outliers_q + CW'(1);
            end else begin
              outliers_q <= outliers_q;
            end
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_IDX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end else begin
            state_q <= COLLECT;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sse      = sse_q;
  assign sae      = sae_q;
  assign max_abs  = max_abs_q;
  assign max_idx  = max_idx_q;
  assign outliers = outliers_q;

endmodule

// File: tb/tb_regression_error_stats.sv
// Directed bench for regression_error_stats. Four instances share clock and
// reset: inst 0 (N=4), inst 1 (N=2), inst 2 (N=3), inst 3 (default N=150).
module tb_regression_error_stats;

  logic        clk;
  logic        reset;
  logic        start_s     [4];
  logic        ei_valid_s  [4];
  logic [19:0] ei_s        [4];
  logic [19:0] threshold_s [4];
  logic        busy_s      [4];
  logic        done_s      [4];
  logic [47:0] sse_s       [4];
  logic [27:0] sae_s       [4];
  logic [19:0] max_abs_s   [4];
  logic [7:0]  max_idx_s   [4];
  logic [7:0]  outliers_s  [4];

  int errors;
  int checks;

  regression_error_stats #(.W(20), .N(4), .CW(8), .SW(48)) u_n4 (
    .clk(clk), .reset(reset), .start(start_s[0]), .ei_valid(ei_valid_s[0]),
    .ei(ei_s[0]), .threshold(threshold_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .sse(sse_s[0]), .sae(sae_s[0]), .max_abs(max_abs_s[0]), .max_idx(max_idx_s[0]),
    .outliers(outliers_s[0]));

  regression_error_stats #(.W(20), .N(2), .CW(8), .SW(48)) u_n2 (
    .clk(clk), .reset(reset), .start(start_s[1]), .ei_valid(ei_valid_s[1]),
    .ei(ei_s[1]), .threshold(threshold_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .sse(sse_s[1]), .sae(sae_s[1]), .max_abs(max_abs_s[1]), .max_idx(max_idx_s[1]),
    .outliers(outliers_s[1]));

  regression_error_stats #(.W(20), .N(3), .CW(8), .SW(48)) u_n3 (
    .clk(clk), .reset(reset), .start(start_s[2]), .ei_valid(ei_valid_s[2]),
    .ei(ei_s[2]), .threshold(threshold_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .sse(sse_s[2]), .sae(sae_s[2]), .max_abs(max_abs_s[2]), .max_idx(max_idx_s[2]),
    .outliers(outliers_s[2]));

  regression_error_stats u_n150 (
    .clk(clk), .reset(reset), .start(start_s[3]), .ei_valid(ei_valid_s[3]),
    .ei(ei_s[3]), .threshold(threshold_s[3]), .busy(busy_s[3]), .done(done_s[3]),
    .sse(sse_s[3]), .sae(sae_s[3]), .max_abs(max_abs_s[3]), .max_idx(max_idx_s[3]),
    .outliers(outliers_s[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int inst);
    start_s[inst] = 1'b1;
    tick();
    start_s[inst] = 1'b0;
  endtask

  // count strobes of one value, gap idle cycles after each strobe
  task automatic feed(input int inst, input logic [19:0] val, input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      ei_valid_s[inst] = 1'b1;
      ei_s[inst]       = val;
      tick();
      ei_valid_s[inst] = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    ei_valid_s[0] = 1'b1;
    ei_s[0]       = 20'd100;
    tick();
    reset = 1'b0;
    tick();
    tick();
    ei_valid_s[0] = 1'b0;
    tick();
    checks++; if (sse_s[0] !== 48'd0)     begin errors++; $display("FAIL reset_sse got=%0d exp=0", sse_s[0]); end
    checks++; if (sae_s[0] !== 28'd0)     begin errors++; $display("FAIL reset_sae got=%0d exp=0", sae_s[0]); end
    checks++; if (max_abs_s[0] !== 20'd0) begin errors++; $display("FAIL reset_max got=%0d exp=0", max_abs_s[0]); end
    checks++; if (outliers_s[0] !== 8'd0 || max_idx_s[0] !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", outliers_s[0], max_idx_s[0]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (busy_s[k] !== 1'b0 || done_s[k] !== 1'b0) begin errors++; $display("FAIL reset_flags inst=%0d got=%b%b exp=00", k, busy_s[k], done_s[k]); end
    end
  endtask

  task automatic test_small();
    threshold_s[0] = 20'd5;
    // start together with a strobe: the strobe must be ignored
    ei_valid_s[0] = 1'b1;
    ei_s[0]       = 20'd50;
    pulse_start(0);
    ei_valid_s[0] = 1'b0;
    checks++; if (busy_s[0] !== 1'b1 || sae_s[0] !== 28'd0) begin errors++; $display("FAIL small_start got busy=%b sae=%0d exp busy=1 sae=0", busy_s[0], sae_s[0]); end
    feed(0, 20'd3, 1, 0);
    feed(0, -20'sd4, 1, 0);
    feed(0, 20'd0, 1, 0);
    checks++; if (done_s[0] !== 1'b0 || sae_s[0] !== 28'd7) begin errors++; $display("FAIL small_partial got done=%b sae=%0d exp done=0 sae=7", done_s[0], sae_s[0]); end
    feed(0, 20'd6, 1, 0);
    checks++; if (done_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin errors++; $display("FAIL small_done got=%b%b exp busy/done=01", busy_s[0], done_s[0]); end
    checks++; if (sse_s[0] !== 48'd61)    begin errors++; $display("FAIL small_sse got=%0d exp=61", sse_s[0]); end
    checks++; if (sae_s[0] !== 28'd13)    begin errors++; $display("FAIL small_sae got=%0d exp=13", sae_s[0]); end
    checks++; if (max_abs_s[0] !== 20'd6) begin errors++; $display("FAIL small_max got=%0d exp=6", max_abs_s[0]); end
    checks++; if (max_idx_s[0] !== 8'd3)  begin errors++; $display("FAIL small_idx got=%0d exp=3", max_idx_s[0]); end
    checks++; if (outliers_s[0] !== 8'd1) begin errors++; $display("FAIL small_outl got=%0d exp=1", outliers_s[0]); end
    // strobes while DONE leave the report untouched
    feed(0, 20'd1000, 2, 1);
    checks++; if (done_s[0] !== 1'b1 || sae_s[0] !== 28'd13 || max_abs_s[0] !== 20'd6) begin errors++; $display("FAIL small_hold got done=%b sae=%0d max=%0d exp 1/13/6", done_s[0], sae_s[0], max_abs_s[0]); end
  endtask

  task automatic test_extremes();
    logic [47:0] exp_sse;
    exp_sse = (48'd1 << 38) + 48'd524287 * 48'd524287;
    threshold_s[1] = 20'd0;
    pulse_start(1);
    feed(1, 20'h80000, 1, 0);
    feed(1, 20'h7FFFF, 1, 0);
    checks++; if (done_s[1] !== 1'b1)           begin errors++; $display("FAIL ext_done got=%b exp=1", done_s[1]); end
    checks++; if (max_abs_s[1] !== 20'd524288)  begin errors++; $display("FAIL ext_max got=%0d exp=524288", max_abs_s[1]); end
    checks++; if (max_idx_s[1] !== 8'd0)        begin errors++; $display("FAIL ext_idx got=%0d exp=0", max_idx_s[1]); end
    checks++; if (sse_s[1] !== exp_sse)         begin errors++; $display("FAIL ext_sse got=%0d exp=%0d", sse_s[1], exp_sse); end
    checks++; if (sae_s[1] !== 28'd1048575)     begin errors++; $display("FAIL ext_sae got=%0d exp=1048575", sae_s[1]); end
    checks++; if (outliers_s[1] !== 8'd2)       begin errors++; $display("FAIL ext_outl got=%0d exp=2", outliers_s[1]); end
  endtask

  task automatic test_ties_gaps();
    threshold_s[2] = 20'd7;
    pulse_start(2);
    feed(2, -20'sd7, 1, 2);
    feed(2, 20'd7, 1, 2);
    checks++; if (done_s[2] !== 1'b0 || busy_s[2] !== 1'b1) begin errors++; $display("FAIL ties_mid got busy/done=%b%b exp=10", busy_s[2], done_s[2]); end
    feed(2, 20'd7, 1, 0);
    checks++; if (done_s[2] !== 1'b1)       begin errors++; $display("FAIL ties_done got=%b exp=1", done_s[2]); end
    checks++; if (max_idx_s[2] !== 8'd0)    begin errors++; $display("FAIL ties_idx got=%0d exp=0", max_idx_s[2]); end
    checks++; if (max_abs_s[2] !== 20'd7)   begin errors++; $display("FAIL ties_max got=%0d exp=7", max_abs_s[2]); end
    checks++; if (outliers_s[2] !== 8'd0)   begin errors++; $display("FAIL ties_outl got=%0d exp=0", outliers_s[2]); end
    checks++; if (sae_s[2] !== 28'd21)      begin errors++; $display("FAIL ties_sae got=%0d exp=21", sae_s[2]); end
    checks++; if (sse_s[2] !== 48'd147)     begin errors++; $display("FAIL ties_sse got=%0d exp=147", sse_s[2]); end
  endtask

  task automatic test_back_to_back();
    threshold_s[3] = 20'd0;
    pulse_start(3);
    feed(3, 20'hFFFFF, 149, 0);
    checks++; if (done_s[3] !== 1'b0)        begin errors++; $display("FAIL full_early got done=%b exp=0", done_s[3]); end
    feed(3, 20'hFFFFF, 1, 0);
    checks++; if (done_s[3] !== 1'b1)        begin errors++; $display("FAIL full_done got=%b exp=1", done_s[3]); end
    checks++; if (sse_s[3] !== 48'd150)      begin errors++; $display("FAIL full_sse got=%0d exp=150", sse_s[3]); end
    checks++; if (sae_s[3] !== 28'd150)      begin errors++; $display("FAIL full_sae got=%0d exp=150", sae_s[3]); end
    checks++; if (max_idx_s[3] !== 8'd0 || max_abs_s[3] !== 20'd1) begin errors++; $display("FAIL full_max got idx=%0d max=%0d exp 0/1", max_idx_s[3], max_abs_s[3]); end
    checks++; if (outliers_s[3] !== 8'd150)  begin errors++; $display("FAIL full_outl got=%0d exp=150", outliers_s[3]); end
    pulse_start(3);
    checks++; if (busy_s[3] !== 1'b1 || done_s[3] !== 1'b0) begin errors++; $display("FAIL restart_flags got busy/done=%b%b exp=10", busy_s[3], done_s[3]); end
    checks++; if (sse_s[3] !== 48'd0 || sae_s[3] !== 28'd0 || outliers_s[3] !== 8'd0) begin errors++; $display("FAIL restart_clear got sse=%0d sae=%0d outl=%0d exp 0/0/0", sse_s[3], sae_s[3], outliers_s[3]); end
  endtask

  task automatic test_midrun_reset();
    // inst 3 is collecting after the restart; abort partway through
    feed(3, 20'd5, 70, 0);
    checks++; if (sae_s[3] !== 28'd350) begin errors++; $display("FAIL abort_partial got sae=%0d exp=350", sae_s[3]); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (busy_s[3] !== 1'b0 || sse_s[3] !== 48'd0 || sae_s[3] !== 28'd0) begin errors++; $display("FAIL async_reset got busy=%b sse=%0d sae=%0d exp 0/0/0", busy_s[3], sse_s[3], sae_s[3]); end
    tick();
    reset = 1'b0;
    tick();
    threshold_s[3] = 20'd1;
    pulse_start(3);
    feed(3, 20'd2, 150, 0);
    checks++; if (done_s[3] !== 1'b1)       begin errors++; $display("FAIL rerun_done got=%b exp=1", done_s[3]); end
    checks++; if (sse_s[3] !== 48'd600)     begin errors++; $display("FAIL rerun_sse got=%0d exp=600", sse_s[3]); end
    checks++; if (sae_s[3] !== 28'd300)     begin errors++; $display("FAIL rerun_sae got=%0d exp=300", sae_s[3]); end
    checks++; if (max_abs_s[3] !== 20'd2 || max_idx_s[3] !== 8'd0) begin errors++; $display("FAIL rerun_max got max=%0d idx=%0d exp 2/0", max_abs_s[3], max_idx_s[3]); end
    checks++; if (outliers_s[3] !== 8'd150) begin errors++; $display("FAIL rerun_outl got=%0d exp=150", outliers_s[3]); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start_s[k]     = 1'b0;
      ei_valid_s[k]  = 1'b0;
      ei_s[k]        = 20'd0;
      threshold_s[k] = 20'd0;
    end
    test_reset();
    test_small();
    test_extremes();
    test_ties_gaps();
    test_back_to_back();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regression_error_stats.md
# regression_error_stats

Downstream consumer of the linear-regression error stream. Accepts the per-sample residuals `ei` (strobed by the error checker's `out_ready`) for one full dataset of N samples and reduces them to summary statistics: sum of squared errors, sum of absolute errors, maximum absolute error with its sample index, and an outlier count against a programmable threshold. Sits after the top-level regression core; its `done` flags a complete fit-quality report.

## Interface
Parameters:
- `W`, 20, residual width (signed two's complement, same format as `ei`)
- `N`, 150, samples per dataset
- `CW`, 8, sample counter / index width (must satisfy 2^CW ≥ N)
- `SW`, 48, SSE accumulator width

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  begin a new dataset collection (sampled in IDLE or DONE only)
- `ei_valid`  in  1  residual strobe; driven by the core's `out_ready`
- `ei`  in  W  signed residual, valid when `ei_valid`=1
- `threshold`  in  W  unsigned outlier threshold, must be held stable during COLLECT
- `busy`  out  1  high in COLLECT
- `done`  out  1  high in DONE (level, held until next `start`)
- `sse`  out  SW  unsigned Σ ei²
- `sae`  out  W+CW  unsigned Σ |ei|
- `max_abs`  out  W  unsigned max |ei|
- `max_idx`  out  CW  index (0-based) of the first sample reaching `max_abs`
- `outliers`  out  CW  count of samples with |ei| > `threshold`

## Operation
- FSM states: IDLE, COLLECT, DONE.
- IDLE/DONE + `start`=1 → clear `sse`, `sae`, `max_abs`, `max_idx`, `outliers`, sample counter; go to COLLECT.
- COLLECT: each cycle with `ei_valid`=1 accepts one sample at index = counter:
  - a = |ei|, computed as W-bit unsigned; a(−2^(W−1)) = 2^(W−1) exactly (no saturation needed).
  - `sse` += a·a (2W-bit product, zero-extended to SW).
  - `sae` += a (zero-extended).
  - if a > `max_abs` (strict): `max_abs` ← a, `max_idx` ← counter. Ties keep earlier index.
  - if a > `threshold` (strict): `outliers` += 1.
  - counter += 1; when the accepted sample is index N−1 → DONE.
- `ei_valid` ignored in IDLE and DONE. `start` ignored in COLLECT.
- Outputs are the live accumulators; they are only defined as a complete result while `done`=1 and hold unchanged throughout DONE.
- Width headroom (defaults): N·2^38 < 2^46 ≤ 2^SW; N·2^19 < 2^27 < 2^(W+CW). No overflow handling required within parameter limits.
- `ei` values outside the accepted cycle have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, all statistic outputs 0, counter 0.
- `start` at edge k → `busy`=1 from k+1; a sample may be accepted at edge k+1.
- Each accepted sample updates all outputs at the same edge it is accepted (single-cycle, combinational abs/multiply).
- N-th accepted sample at edge m → `busy`=0, `done`=1 after edge m, final values visible simultaneously.
- Back-to-back `ei_valid` every cycle supported; gaps of any length allowed.
- `start` while DONE: single cycle later `done`=0, `busy`=1, outputs zeroed.
- `reset` asserted mid-COLLECT: immediate return to IDLE with all outputs 0, independent of `clk`; partial dataset discarded.
- `start` and `ei_valid` in the same IDLE cycle: start taken, sample ignored.

## Test plan
- Reset/idle: assert `reset`, pulse `ei_valid` with `ei`=100 while in IDLE → all outputs 0, `busy`=`done`=0.
- Small dataset (N=4, threshold=5): ei = 3, −4, 0, 6 contiguous → `sse`=61, `sae`=13, `max_abs`=6, `max_idx`=3, `outliers`=1, `done`=1 one cycle after 4th sample.
- Extremes (N=2): ei = −524288, 524287 → `max_abs`=524288, `max_idx`=0, `sse`=2^38+(2^19−1)^2, `sae`=1048575.
- Ties and gaps (N=3, threshold=7): ei = −7, 7, 7 with 2 idle cycles between strobes → `max_idx`=0, `outliers`=0, `sae`=21, `sse`=147.
- Full default run: 150 samples of ei=−1 → `sse`=150, `sae`=150, `max_idx`=0; then `start` again → outputs cleared next cycle, `busy`=1.
- Mid-run reset: reset asynchronously after 70 of 150 samples, then start and feed 150 samples of ei=2 → `sse`=600, `sae`=300, no residue from aborted run.
